seg7_scan: RTL and testbench

//  Multiplexed 4-digit hex seven-segment driver, downstream of the IO block's GPIO output register.
//  - din is wired to gpio_out, the register at address 0x101.
//  - The 16-bit value is shown as four hex nibbles, one digit lit at a time.
//  - Blanking gaps between digits prevent ghosting.
//  - The value is frame-latched so a display frame never mixes old and new nibbles.

---
 rtl/seg7_scan_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 37 +++
 rtl/seg7_scan.sv | 119 +++++++++++
 tb/tb_seg7_scan.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg
//   Shared definitions for the multiplexed seven-segment scanner:
//   - active-high segment patterns for hex digits 0..F, bit order gfedcba
//   - scan FSM state encoding (BLANK = 1'b0, DRIVE = 1'b1)
//   - msd_idx(): index of the most-significant nonzero nibble, used by the
//     optional leading-zero blanking (SEG7_LZB_EN)
package seg7_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Highest digit that must be shown; an all-zero value still shows digit 0.
  function automatic logic [1:0] msd_idx(input logic [15:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[7:4]   != 4'h0) r = 2'd1;
    if (v[11:8]  != 4'h0) r = 2'd2;
    if (v[15:12] != 4'h0) r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational hex nibble to seven-segment decoder, active-high output.
//   Display polarity is applied by the instantiating scanner.
//   Ports:
//     nib  in  4  hex digit value
//     seg  out 7  segment pattern, seg[0]=a .. seg[6]=g
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan
//   Multiplexed 4-digit hex seven-segment driver fed from the GPIO output
//   register. Each digit owns a slot of CLK_DIV clocks; the first BLANK_CYC
//   clocks of every slot are blank to avoid ghosting. The displayed value is
//   captured into a shadow register only at the end of digit 3, so a frame
//   never mixes old and new nibbles.
//   Optional feature: define SEG7_LZB_EN for leading-zero blanking (digits
//   above the most-significant nonzero nibble stay dark; digit 0 always lit).
//   Ports:
//     clk    in   1   system clock, rising edge
//     rst_n  in   1   asynchronous active-low reset
//     din    in   16  value to display (synchronous to clk)
//     seg    out  7   segments, seg[0]=a .. seg[6]=g
//     an     out  4   digit enables, an[0] = least-significant nibble
//   Parameters: DW (must be 16), CLK_DIV (>=2), BLANK_CYC (1..CLK_DIV-1),
//   SEG_POL (0 active-high, 1 active-low outputs).
//   The scan FSM state is held in the internal signal 'state' (BLANK/DRIVE).
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int DW        = 16,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 4,
  parameter int SEG_POL   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [6:0]    seg,
  output logic [3:0]    an
);

  localparam int            CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);
  localparam logic [6:0]    SEG_OFF = (SEG_POL != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0]    AN_OFF  = (SEG_POL != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [DW-1:0] shadow;
  state_t        state;
  state_t        state_nxt;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          digit_on;
  logic          slot_end;

  assign slot_end = (cnt == CNT_MAX);

  // Next-cycle slot position and state. Outputs are registered from these
  // so an/seg line up exactly with the cycles where state is DRIVE.
  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    state_nxt = state;
    if (slot_end) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end
    case (state)
      BLANK:   if (cnt_nxt == CNT_BLK) state_nxt = DRIVE;
      DRIVE:   if (slot_end)           state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  always_comb begin
    nib = shadow[3:0];
    case (idx_nxt)
      2'd0:    nib = shadow[3:0];
      2'd1:    nib = shadow[7:4];
      2'd2:    nib = shadow[11:8];
      2'd3:    nib = shadow[15:12];
      default: nib = shadow[3:0];
    endcase
  end

  seg7_decode u_decode (
    .nib (nib),
    .seg (seg_dec)
  );

`ifdef SEG7_LZB_EN
  // shadow is already stable by the first DRIVE cycle of a frame because the
  // latch edge always falls in a BLANK cycle.
  assign digit_on = (idx_nxt <= msd_idx(shadow));
`else
  assign digit_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= 2'd0;
      shadow <= '0;
      state  <= BLANK;
      an     <= AN_OFF;
      seg    <= SEG_OFF;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
      if (slot_end && (idx == 2'd3)) begin
        shadow <= din;
      end
      if ((state_nxt == DRIVE) && digit_on) begin
        an  <= (4'b0001 << idx_nxt) ^ AN_OFF;
        seg <= seg_dec ^ SEG_OFF;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan
//   Directed bench for seg7_scan with CLK_DIV=8, BLANK_CYC=2, SEG_POL=0.
//   The bench tracks the slot position (b_cnt, b_idx) itself from reset
//   release and compares an/seg on the falling edge against hand-written
//   digit patterns. Build with +define+SEG7_LZB_EN to exercise blanking.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int b_cnt = 0;
  int b_idx = 0;

  logic [6:0] pats [4];
  logic [3:0] lit;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  seg7_scan #(
    .DW        (16),
    .CLK_DIV   (8),
    .BLANK_CYC (2),
    .SEG_POL   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .seg   (seg),
    .an    (an)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one clock and the bench's own slot position; returns on negedge.
  task automatic tick();
    @(posedge clk);
    if (b_cnt == 7) begin
      b_cnt = 0;
      b_idx = (b_idx + 1) % 4;
    end else begin
      b_cnt = b_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic set_expect();
    if (b_cnt >= 2 && lit[b_idx]) begin
      exp_an  = 4'b0001 << b_idx;
      exp_seg = pats[b_idx];
    end else begin
      exp_an  = 4'h0;
      exp_seg = 7'h00;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din   = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (an !== 4'h0) begin
      errors++;
      $display("FAIL reset_an got=%b want=0000", an);
    end
    checks++;
    if (seg !== 7'h00) begin
      errors++;
      $display("FAIL reset_seg got=%h want=00", seg);
    end
    rst_n = 1'b1;
    b_cnt = 0;
    b_idx = 0;
    din   = 16'h1234;
    pats  = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
    lit   = 4'b1111;
    checks++;
    if (an !== 4'h0) begin
      errors++;
      $display("FAIL release_an got=%b want=0000", an);
    end
    for (int i = 0; i < 31; i++) begin
      tick();
      set_expect();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL frame1 idx=%0d cnt=%0d an=%b seg=%h want an=%b seg=%h",
                 b_idx, b_cnt, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_frame_latch();
    pats = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    lit  = 4'b1111;
    for (int i = 0; i < 32; i++) begin
      tick();
      set_expect();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL frame2_1234 idx=%0d cnt=%0d an=%b seg=%h want an=%b seg=%h",
                 b_idx, b_cnt, an, seg, exp_an, exp_seg);
      end
      if (b_idx == 1 && b_cnt == 3) din = 16'hABCD;
    end
  endtask

  task automatic test_mid_frame_change();
    pats = '{7'h5E, 7'h39, 7'h7C, 7'h77};
    lit  = 4'b1111;
    for (int i = 0; i < 32; i++) begin
      tick();
      set_expect();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL frame3_abcd idx=%0d cnt=%0d an=%b seg=%h want an=%b seg=%h",
                 b_idx, b_cnt, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_blanking();
    int zero_n;
    int one_n;
    int multi_n;
    for (int s = 0; s < 16; s++) begin
      zero_n  = 0;
      one_n   = 0;
      multi_n = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (an == 4'h0)      zero_n++;
        else if ($onehot(an)) one_n++;
        else                 multi_n++;
      end
      checks++;
      if (zero_n != 2) begin
        errors++;
        $display("FAIL blank_count slot=%0d got=%0d want=2", s, zero_n);
      end
      checks++;
      if (one_n != 6) begin
        errors++;
        $display("FAIL drive_count slot=%0d got=%0d want=6", s, one_n);
      end
      checks++;
      if (multi_n != 0) begin
        errors++;
        $display("FAIL multi_an slot=%0d got=%0d want=0", s, multi_n);
      end
    end
  endtask

  task automatic test_async_reset();
    // Move to a DRIVE cycle of digit 2 (bounded: at most one frame).
    for (int i = 0; i < 40 && !(b_idx == 2 && b_cnt == 4); i++) tick();
    checks++;
    if (an !== 4'b0100 || seg !== 7'h7C) begin
      errors++;
      $display("FAIL pre_reset_drive an=%b seg=%h want an=0100 seg=7c", an, seg);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'h0 || seg !== 7'h00) begin
      errors++;
      $display("FAIL async_reset an=%b seg=%h want an=0000 seg=00", an, seg);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b_cnt = 0;
    b_idx = 0;
    pats  = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
    lit   = 4'b1111;
    for (int i = 0; i < 31; i++) begin
      tick();
      set_expect();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL post_reset_zero idx=%0d cnt=%0d an=%b seg=%h want an=%b seg=%h",
                 b_idx, b_cnt, an, seg, exp_an, exp_seg);
      end
    end
    pats = '{7'h5E, 7'h39, 7'h7C, 7'h77};
    for (int i = 0; i < 32; i++) begin
      tick();
      set_expect();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL post_reset_relatch idx=%0d cnt=%0d an=%b seg=%h want an=%b seg=%h",
                 b_idx, b_cnt, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_lzb();
    // Bench sits at the last cycle of a frame: the next edge latches din.
    din  = 16'h0050;
    pats = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
`ifdef SEG7_LZB_EN
    lit = 4'b0011;
`else
    lit = 4'b1111;
`endif
    for (int i = 0; i < 32; i++) begin
      tick();
      set_expect();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL lzb_0050 idx=%0d cnt=%0d an=%b seg=%h want an=%b seg=%h",
                 b_idx, b_cnt, an, seg, exp_an, exp_seg);
      end
    end
    din  = 16'h0000;
    pats = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
`ifdef SEG7_LZB_EN
    lit = 4'b0001;
`else
    lit = 4'b1111;
`endif
    for (int i = 0; i < 32; i++) begin
      tick();
      set_expect();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL lzb_0000 idx=%0d cnt=%0d an=%b seg=%h want an=%b seg=%h",
                 b_idx, b_cnt, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_latch();
    test_mid_frame_change();
    test_blanking();
    test_async_reset();
    test_lzb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
